// File: rtl/mem_access_pkg.sv
// Shared types and sizing for the memory-stage access controller.
package mem_access_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CTR_W      = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    HALTED
  } ctrlState_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side and memory-side signals of the MEM-stage controller.
interface mem_access_ctrl_if
  import mem_access_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              in_valid;
  logic              in_read;
  logic              in_write;
  logic [DATA_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic              in_halt;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic              pipe_stall;
  logic              out_valid;
  logic [DATA_W-1:0] out_rdata;
  logic              out_err;
  logic              out_halt;

  // The controller itself
  modport master (
    input  in_valid, in_read, in_write, in_addr, in_wdata, in_halt,
    input  mem_rdata, mem_done,
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    output pipe_stall, out_valid, out_rdata, out_err, out_halt
  );

  // Pipeline registers and data memory around it
  modport slave (
    output in_valid, in_read, in_write, in_addr, in_wdata, in_halt,
    output mem_rdata, mem_done,
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    input  pipe_stall, out_valid, out_rdata, out_err, out_halt
  );

endinterface

// File: rtl/mem_wait_ctr.sv
// Wait-cycle counter for an outstanding memory access; flags the cycle whose
// increment would reach MAX_WAIT so the FSM can give up on the access.
module mem_wait_ctr
  import mem_access_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [CTR_W-1:0] LAST = CTR_W'(MAX_WAIT - 1);

  logic [CTR_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CTR_W'(1);
    end
  end

  assign terminal = enable && (count == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: issues multi-cycle loads/stores, stalls the
// pipeline while one is outstanding and hands registered results to MEM/WB.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 15
) (
  input logic         clk,
  input logic         rst,
  mem_access_ctrl_if.master bus
);

  ctrlState_e        state;
  logic              isReadOp;
  logic [DATA_W-1:0] addrReg;
  logic [DATA_W-1:0] wdataReg;
  logic              outValid;
  logic [DATA_W-1:0] outRdata;
  logic              outErr;
  logic              outHalt;
  logic              memOp;
  logic              accept;
  logic              ctrEnable;
  logic              ctrTerminal;

  // Gating with rst keeps request/stall outputs low while reset is held,
  // even if EX/MEM still presents a live memory op.
  assign memOp  = bus.in_read | bus.in_write;
  assign accept = rst && (state == IDLE) && bus.in_valid && memOp &&
                  !bus.in_addr[0] && !bus.in_halt;

  assign bus.mem_rd     = accept & bus.in_read;
  assign bus.mem_wr     = accept & bus.in_write & ~bus.in_read;
  assign bus.mem_addr   = accept ? bus.in_addr  : addrReg;
  assign bus.mem_wdata  = accept ? bus.in_wdata : wdataReg;
  assign bus.pipe_stall = accept || (state == BUSY) || (state == HALTED);

  assign bus.out_valid = outValid;
  assign bus.out_rdata = outRdata;
  assign bus.out_err   = outErr;
  assign bus.out_halt  = outHalt;

  assign ctrEnable = (state == BUSY) && !bus.mem_done;

  mem_wait_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) waitCtr (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .enable   (ctrEnable),
    .terminal (ctrTerminal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      isReadOp <= 1'b0;
      addrReg  <= '0;
      wdataReg <= '0;
      outValid <= 1'b0;
      outRdata <= '0;
      outErr   <= 1'b0;
      outHalt  <= 1'b0;
    end else begin
      outValid <= 1'b0;
      outRdata <= '0;
      outErr   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.in_halt) begin
              outValid <= 1'b1;
              outHalt  <= 1'b1;
              state    <= HALTED;
            end else if (memOp && bus.in_addr[0]) begin
              outValid <= 1'b1;
              outErr   <= 1'b1;
            end else if (memOp) begin
              isReadOp <= bus.in_read;
              addrReg  <= bus.in_addr;
              wdataReg <= bus.in_wdata;
              state    <= BUSY;
            end else begin
              outValid <= 1'b1;
            end
          end
        end
        // A completion arriving on the timeout cycle still counts as success
        BUSY: begin
          if (bus.mem_done) begin
            outValid <= 1'b1;
            outRdata <= isReadOp ? bus.mem_rdata : '0;
            state    <= RESP;
          end else if (ctrTerminal) begin
            outValid <= 1'b1;
            outErr   <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        HALTED: begin
          outHalt <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
